// File: rtl/hall_velocity_estimator.sv
// hall_velocity_estimator: debounced Hall step counter reporting signed steps per fixed window.
// Flags invalid codes (000/111) and skipped states as a sticky fault.
module hall_velocity_estimator #(
  parameter int WINDOW_CYCLES   = 50000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int VEL_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [2:0]                  hall,
  input  logic                        clear_fault,
  output logic signed [VEL_WIDTH-1:0] actual_velocity,
  output logic                        velocity_valid,
  output logic                        direction,
  output logic                        hall_fault
);
  localparam int WW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0] UNKNOWN = 3'd7;
  localparam logic signed [VEL_WIDTH:0] VMAX = {2'b00, {(VEL_WIDTH-1){1'b1}}};
  localparam logic signed [VEL_WIDTH:0] VMIN = {2'b11, {(VEL_WIDTH-1){1'b0}}};

  logic [2:0] s1, s2, cand, acc_code, ref_idx, new_idx, ref_next, ref_prev;
  logic [DW-1:0] deb;
  logic [WW-1:0] win;
  logic signed [VEL_WIDTH-1:0] acc;
  logic signed [VEL_WIDTH:0] sum, sat;
  logic accept, fwd, bwd, fault_ev, last;

  // Position in the forward sequence 001,011,010,110,100,101; invalid codes map to UNKNOWN
  function automatic logic [2:0] idx_of(input logic [2:0] c);
    case (c)
      3'b001:  return 3'd0;
      3'b011:  return 3'd1;
      3'b010:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b101:  return 3'd5;
      default: return UNKNOWN;
    endcase
  endfunction

  assign accept   = (s2 == cand) && (deb == DW'(DEBOUNCE_CYCLES - 1)) && (cand != acc_code);
  assign new_idx  = idx_of(cand);
  assign ref_next = (ref_idx == 3'd5) ? 3'd0 : ref_idx + 3'd1;
  assign ref_prev = (ref_idx == 3'd0) ? 3'd5 : ref_idx - 3'd1;
  assign fwd      = accept && ref_idx != UNKNOWN && new_idx != UNKNOWN && new_idx == ref_next;
  assign bwd      = accept && ref_idx != UNKNOWN && new_idx != UNKNOWN && new_idx == ref_prev;
  assign fault_ev = accept && (new_idx == UNKNOWN || (ref_idx != UNKNOWN && !fwd && !bwd));
  assign last     = win == WW'(WINDOW_CYCLES - 1);
  assign velocity_valid = last;

  always_comb begin
    sum = {acc[VEL_WIDTH-1], acc} + (fwd ? (VEL_WIDTH+1)'(1) : bwd ? -(VEL_WIDTH+1)'(1) : '0);
    sat = (sum > VMAX) ? VMAX : (sum < VMIN) ? VMIN : sum;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1              <= '0;
      s2              <= '0;
      cand            <= '0;
      deb             <= '0;
      acc_code        <= '0;
      ref_idx         <= UNKNOWN;
      win             <= '0;
      acc             <= '0;
      actual_velocity <= '0;
      direction       <= 1'b1;
      hall_fault      <= 1'b0;
    end else begin
      s1 <= hall;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        deb  <= '0;
      end else if (deb != DW'(DEBOUNCE_CYCLES)) deb <= deb + 1'b1;
      // An invalid code maps to UNKNOWN, so every accepted code simply becomes the reference
      if (accept) begin
        acc_code <= cand;
        ref_idx  <= new_idx;
      end
      direction  <= fwd | (direction & ~bwd);
      hall_fault <= fault_ev | (hall_fault & ~clear_fault);
      win        <= last ? '0 : win + 1'b1;
      acc        <= last ? '0 : sat[VEL_WIDTH-1:0];
      if (last) actual_velocity <= sat[VEL_WIDTH-1:0];
    end
endmodule

// File: tb/tb_hall_velocity_estimator.sv
// tb_hall_velocity_estimator: random Hall traffic checked against a step-counting reference model.
module tb_hall_velocity_estimator;
  localparam int W  = 600;
  localparam int D  = 3;
  localparam int VW = 8;

  logic clk = 0, reset_n = 0, clear_fault = 0;
  logic [2:0] hall = 3'b001;
  logic signed [VW-1:0] actual_velocity;
  logic velocity_valid, direction, hall_fault;

  hall_velocity_estimator #(.WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D), .VEL_WIDTH(VW)) dut (
    .clk(clk), .reset_n(reset_n), .hall(hall), .clear_fault(clear_fault),
    .actual_velocity(actual_velocity), .velocity_valid(velocity_valid),
    .direction(direction), .hall_fault(hall_fault));

  always #5 clk = ~clk;

  int seq[6] = '{1, 3, 2, 6, 4, 5};
  int checks = 0, errors = 0, cyc = 0, cur = 0;
  logic pv = 0;

  int m_dly[2], m_prev, m_run, m_acc_code, m_ref, m_fault, m_dir, m_vel, m_acc, m_win;

  function automatic int seq_index(input int c);
    for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  function automatic int sat(input int x);
    return (x > 2**(VW-1) - 1) ? 2**(VW-1) - 1 : (x < -(2**(VW-1))) ? -(2**(VW-1)) : x;
  endfunction

  // Reference: a code counts once it has been seen for D+1 samples after a 2-sample delay
  always @(posedge clk) begin
    int v, idx, st, d;
    logic ev;
    if (!reset_n) begin
      m_dly = '{0, 0}; m_prev = 0; m_run = 1; m_acc_code = 0; m_ref = -1;
      m_fault = 0; m_dir = 1; m_vel = 0; m_acc = 0; m_win = 0;
    end else begin
      v = m_dly[1]; m_dly[1] = m_dly[0]; m_dly[0] = int'(hall);
      if (v == m_prev) m_run++;
      else begin m_prev = v; m_run = 1; end
      st = 0; ev = 0;
      if (m_run == D + 1 && v != m_acc_code) begin
        m_acc_code = v;
        idx = seq_index(v);
        if (idx < 0) begin ev = 1; m_ref = -1; end
        else if (m_ref < 0) m_ref = idx;
        else begin
          d = (idx - m_ref + 6) % 6;
          if (d == 1) begin st = 1; m_dir = 1; end
          else if (d == 5) begin st = -1; m_dir = 0; end
          else ev = 1;
          m_ref = idx;
        end
      end
      if (ev) m_fault = 1;
      else if (clear_fault) m_fault = 0;
      if (m_win == W - 1) begin m_vel = sat(m_acc + st); m_acc = 0; m_win = 0; end
      else begin m_acc = sat(m_acc + st); m_win++; end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (m_win == W - 1 || velocity_valid || pv || cyc % 8 == 0) begin
      check("valid", int'(velocity_valid), int'(m_win == W - 1));
      check("velocity", int'(actual_velocity), m_vel);
      check("direction", int'(direction), m_dir);
      check("fault", int'(hall_fault), m_fault);
    end
    pv = velocity_valid;
  endtask

  task automatic put(input int code, input int n);
    hall = 3'(code);
    clear_fault = ($urandom_range(0, 15) == 0);
    for (int i = 0; i < n; i++) begin
      tick();
      clear_fault = 0;
    end
  endtask

  task automatic wait_win(input int target);
    int n = 0;
    while (m_win != target && n < 2 * W) begin tick(); n++; end
    check("wait_window", m_win, target);
  endtask

  initial begin
    int n;
    reset_n = 0;
    repeat (3) tick();
    check("reset_velocity", int'(actual_velocity), 0);
    check("reset_direction", int'(direction), 1);
    check("reset_fault", int'(hall_fault), 0);
    reset_n = 1;
    for (int i = 0; i < 400; i++) begin cur = (cur + 1) % 6; put(seq[cur], 12); end
    for (int i = 0; i < 400; i++) begin cur = (cur + 5) % 6; put(seq[cur], 12); end
    for (int i = 0; i < 300; i++) begin cur = (cur + 1) % 6; put(seq[cur], D + 1); end
    for (int i = 0; i < 300; i++) begin cur = (cur + 5) % 6; put(seq[cur], D + 1); end
    put(7, 20);
    cur = 1; put(seq[cur], 20);
    hall = 3'(seq[cur]); clear_fault = 1; tick(); clear_fault = 0;
    repeat (5) tick();
    for (int i = 0; i < 500; i++) begin
      int op = int'($urandom_range(0, 9));
      if (op < 4) begin cur = (cur + 1) % 6; put(seq[cur], int'($urandom_range(D + 1, 25))); end
      else if (op < 7) begin cur = (cur + 5) % 6; put(seq[cur], int'($urandom_range(D + 1, 25))); end
      else if (op == 7) begin
        put(seq[(cur + int'($urandom_range(1, 5))) % 6], int'($urandom_range(1, D)));
        put(seq[cur], D + 2);
      end else if (op == 8) begin
        put($urandom_range(0, 1) ? 7 : 0, int'($urandom_range(1, 20)));
        cur = int'($urandom_range(0, 5));
        put(seq[cur], D + 2);
      end else begin
        cur = (cur + int'($urandom_range(2, 4))) % 6;
        put(seq[cur], int'($urandom_range(D + 1, 25)));
      end
    end
    put(seq[cur], 30);
    wait_win(W - 3 - D);
    cur = (cur + 1) % 6;
    put(seq[cur], 2 * W);
    wait_win(W / 2);
    reset_n = 0;
    repeat (3) tick();
    check("midreset_velocity", int'(actual_velocity), 0);
    check("midreset_direction", int'(direction), 1);
    check("midreset_fault", int'(hall_fault), 0);
    hall = 3'b001;
    reset_n = 1;
    n = 0;
    do begin tick(); n++; end while (!velocity_valid && n < 2 * W);
    check("reset_to_pulse", n, W - 1);
    repeat (20) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
